// File: rtl/pio_rd_arb_if.sv
// rtl/pio_rd_arb_if.sv - requester, response and PIO read channel bundle for pio_rd_arb
interface pio_rd_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          m_addr;
    logic                 m_avalid;
    logic                 m_aready;
    logic [31:0]          m_data;
    logic                 m_dvalid;
    logic                 m_dready;
    logic                 m_resp;

    // Arbiter side: serves the requesters and drives the PIO read channel.
    modport slave (
        input  req_valid, req_addr, rsp_ready, m_aready, m_data, m_dvalid, m_resp,
        output req_ready, rsp_valid, rsp_data, rsp_err, m_addr, m_avalid, m_dready
    );

    // Environment side: the requesters plus the PIO target.
    modport master (
        output req_valid, req_addr, rsp_ready, m_aready, m_data, m_dvalid, m_resp,
        input  req_ready, rsp_valid, rsp_data, rsp_err, m_addr, m_avalid, m_dready
    );
endinterface

// File: rtl/pio_rd_arb.sv
// rtl/pio_rd_arb.sv - round-robin arbiter sharing one PIO read channel among NREQ requesters
module pio_rd_arb #(
    parameter int NREQ = 4,
    parameter int TMO  = 255
) (
    input  logic        clk,
    input  logic        reset,
    pio_rd_arb_if.slave bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [LW-1:0] LAST_INIT = LW'(NREQ - 1);
    localparam logic [CW-1:0] TMO_MAX   = CW'(TMO);
    // Timeout fires on the TMO-th DATA cycle without data.
    localparam logic [CW-1:0] TMO_LAST  = CW'((TMO > 0) ? TMO - 1 : 0);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state;
    logic [LW-1:0]   last_grant;
    logic [LW-1:0]   grant;
    logic [CW-1:0]   tmo_cnt;
    // Set after a timeout: keep m_dready high so a late beat is swallowed.
    logic            drain;

    logic [LW-1:0]   pick;
    logic            pick_ok;
    logic [31:0]     pick_addr;

    // Round-robin pick: first valid index above last_grant, else wrap to the lowest valid.
    always_comb begin
        pick      = last_grant;
        pick_ok   = 1'b0;
        pick_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_ok && bus.req_valid[i] && (LW'(i) > last_grant)) begin
                pick    = LW'(i);
                pick_ok = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_ok && bus.req_valid[i] && (LW'(i) <= last_grant)) begin
                pick    = LW'(i);
                pick_ok = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (LW'(i) == pick) begin
                pick_addr = bus.req_addr[i*32 +: 32];
            end
        end
    end

    // Single-read FSM: grant, address phase, data phase with timeout, response hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= LAST_INIT;
            grant         <= '0;
            tmo_cnt       <= '0;
            drain         <= 1'b0;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_avalid  <= 1'b0;
            bus.m_dready  <= 1'b0;
        end else begin
            bus.req_ready <= '0;

            if (drain && bus.m_dvalid && (state != DATA)) begin
                drain        <= 1'b0;
                bus.m_dready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        bus.req_ready <= NREQ'(1) << pick;
                        bus.m_addr    <= pick_addr;
                        last_grant    <= pick;
                        grant         <= pick;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_avalid && bus.m_aready) begin
                        bus.m_avalid <= 1'b0;
                        bus.m_dready <= 1'b1;
                        drain        <= 1'b0;
                        tmo_cnt      <= '0;
                        state        <= DATA;
                    end else begin
                        bus.m_avalid <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.m_dvalid) begin
                        bus.rsp_data  <= bus.m_data;
                        bus.rsp_err   <= bus.m_resp;
                        bus.rsp_valid <= NREQ'(1) << grant;
                        bus.m_dready  <= 1'b0;
                        state         <= RESP;
                    end else begin
                        if (tmo_cnt != TMO_MAX) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                        if (tmo_cnt >= TMO_LAST) begin
                            bus.rsp_data  <= '0;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= NREQ'(1) << grant;
                            drain         <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (|(bus.rsp_ready & bus.rsp_valid)) begin
                        bus.rsp_valid <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
